// File: rtl/multiplier_pkg.sv
// Shared constants for the pipelined 64x64 multiplier.
// Defining MULTIPLIER_SIGNED_EN switches the datapath to two's complement.
package multiplier_pkg;

  localparam int WIDTH   = 64;
  localparam int HALF_W  = WIDTH / 2;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int LATENCY = 3;

`ifdef MULTIPLIER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

endpackage

// File: rtl/mult_channel.sv
// Registered AW x BW multiplier with enable and synchronous reset.
// Each operand can independently be treated as signed or unsigned.
module mult_channel #(
  parameter int AW       = 64,
  parameter int BW       = 32,
  parameter bit A_SIGNED = 1'b0,
  parameter bit B_SIGNED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [AW-1:0]    i_a,
  input  logic [BW-1:0]    i_b,
  output logic [AW+BW-1:0] o_prod
);

  localparam int PW = AW + BW;

  logic [PW-1:0] w_aExt;
  logic [PW-1:0] w_bExt;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] r_prod;

  // Extending both operands to the full product width and keeping the low PW
  // bits gives the exact result for every signed/unsigned combination.
  assign w_aExt = {{BW{A_SIGNED & i_a[AW-1]}}, i_a};
  assign w_bExt = {{AW{B_SIGNED & i_b[BW-1]}}, i_b};
  assign w_prod = w_aExt * w_bExt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/multiplier_64x64.sv
// Three-stage WIDTH x WIDTH -> 2*WIDTH multiplier built from two half-width channels.
// Unsigned by default; MULTIPLIER_SIGNED_EN selects two's complement operands.
module multiplier_64x64
  import multiplier_pkg::*;
#(
  parameter int WIDTH = multiplier_pkg::WIDTH
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p,
  output logic               p_valid
);

  localparam int HW = WIDTH / 2;
  localparam int CW = WIDTH + HW;
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_v1;
  logic             r_v2;
  logic             r_v3;
  logic [PW-1:0]    r_p;

  logic [CW-1:0]    w_prodL;
  logic [CW-1:0]    w_prodH;
  logic [PW-1:0]    w_extL;
  logic [PW-1:0]    w_extH;
  logic [PW-1:0]    w_sum;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_x  <= '0;
      r_y  <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_p  <= '0;
    end else if (clk_en) begin
      r_x  <= x;
      r_y  <= y;
      r_v1 <= 1'b1;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_p  <= w_sum;
    end
  end

  // The low half of y never carries a sign, so only channel H sees a signed b.
  mult_channel #(
    .AW(WIDTH), .BW(HW), .A_SIGNED(SIGNED_MODE), .B_SIGNED(1'b0)
  ) u_chanL (
    .i_clk(clk_in), .i_rst(rst), .i_en(clk_en),
    .i_a(r_x), .i_b(r_y[HW-1:0]), .o_prod(w_prodL)
  );

  mult_channel #(
    .AW(WIDTH), .BW(HW), .A_SIGNED(SIGNED_MODE), .B_SIGNED(SIGNED_MODE)
  ) u_chanH (
    .i_clk(clk_in), .i_rst(rst), .i_en(clk_en),
    .i_a(r_x), .i_b(r_y[WIDTH-1:HW]), .o_prod(w_prodH)
  );

  assign w_extL = {{HW{SIGNED_MODE & w_prodL[CW-1]}}, w_prodL};
  assign w_extH = {{HW{SIGNED_MODE & w_prodH[CW-1]}}, w_prodH};
  assign w_sum  = w_extL + (w_extH << HW);

  assign p       = r_p;
  assign p_valid = r_v3;

endmodule

// File: tb/tb_multiplier_64x64.sv
// Scoreboard bench for multiplier_64x64: the driver queues expected products,
// a negedge monitor pops and checks them whenever an enabled edge yields a result.
module tb_multiplier_64x64;
  import multiplier_pkg::*;

  localparam int W  = WIDTH;
  localparam int PW = PROD_W;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          clk_en = 1'b0;
  logic [W-1:0]  x      = '0;
  logic [W-1:0]  y      = '0;
  logic [PW-1:0] p;
  logic          p_valid;

  logic [PW-1:0] sbQ[$];
  int            total = 0;
  int            bad   = 0;

  logic          edgeEn;
  logic          edgeRst;
  logic          seenEdge = 1'b0;
  logic [PW-1:0] modelP = '0;
  logic          modelValid = 1'b0;

  always #5 clk_in = ~clk_in;

  multiplier_64x64 #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst(rst), .clk_en(clk_en),
    .x(x), .y(y), .p(p), .p_valid(p_valid)
  );

  function automatic logic [PW-1:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULTIPLIER_SIGNED_EN
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    return {{(PW-W){1'b0}}, a} * {{(PW-W){1'b0}}, b};
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk_in) begin
    edgeEn   <= clk_en;
    edgeRst  <= rst;
    seenEdge <= 1'b1;
  end

  // Three queued operand pairs after an enabled edge means the oldest is due on p.
  always @(negedge clk_in) begin
    if (seenEdge) begin
      if (edgeRst) begin
        modelP     = '0;
        modelValid = 1'b0;
        checkOutput("resetP", p, '0);
        checkOutput("resetValid", {{(PW-1){1'b0}}, p_valid}, '0);
      end else if (edgeEn) begin
        modelValid = (sbQ.size() >= LATENCY);
        checkOutput("validLatency", {{(PW-1){1'b0}}, p_valid}, {{(PW-1){1'b0}}, modelValid});
        if (modelValid) begin
          modelP = sbQ.pop_front();
          checkOutput("product", p, modelP);
        end
      end else begin
        checkOutput("holdValid", {{(PW-1){1'b0}}, p_valid}, {{(PW-1){1'b0}}, modelValid});
        if (modelValid) checkOutput("holdP", p, modelP);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] exp);
    x      = a;
    y      = b;
    clk_en = 1'b1;
    rst    = 1'b0;
    @(posedge clk_in);
    sbQ.push_back(exp);
    #1;
  endtask

  task automatic idleCycles(input int n);
    clk_en = 1'b0;
    repeat (n) begin
      x = {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic resetPulse(input int n, input logic en);
    rst    = 1'b1;
    clk_en = en;
    repeat (n) @(posedge clk_in);
    sbQ.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic applyRandom(input int n);
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < n; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      applyStimulus(a, b, refMul(a, b));
    end
  endtask

  initial begin
    resetPulse(2, 1'b0);

    applyStimulus(64'd3, 64'd5, 128'd15);
`ifdef MULTIPLIER_SIGNED_EN
    applyStimulus({W{1'b1}}, {W{1'b1}}, 128'd1);
    applyStimulus({W{1'b1}}, 64'd2, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE);
`else
    applyStimulus({W{1'b1}}, {W{1'b1}}, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
    applyStimulus({W{1'b1}}, 64'd2, 128'h0000000000000001_FFFFFFFFFFFFFFFE);
`endif
    applyStimulus(64'h8000000000000000, 64'h8000000000000000, 128'h40000000000000000000000000000000);
    applyStimulus(64'd8563214857120369541, 64'd6579858412322574896,
                  refMul(64'd8563214857120369541, 64'd6579858412322574896));
    applyStimulus(64'h0000000100000000, 64'h0000000100000000, 128'h00000000000000010000000000000000);
    applyStimulus(64'd0, {W{1'b1}}, 128'd0);

    // Freeze a full pipe, then confirm results resume in order.
    applyRandom(4);
    idleCycles(5);
    applyRandom(4);

    applyRandom(500);
    idleCycles(3);
    applyRandom(500);

    // Single-cycle reset while the pipe is full discards everything in flight.
    applyRandom(3);
    resetPulse(1, 1'b1);
    applyStimulus(64'd7, 64'd6, 128'd42);
    applyStimulus(64'd1, 64'd1, 128'd1);
    applyStimulus(64'hFFFFFFFF, 64'hFFFFFFFF, 128'h0000000000000000_FFFFFFFE00000001);

    applyStimulus('0, '0, '0);
    applyStimulus('0, '0, '0);
    applyStimulus('0, '0, '0);
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
